// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB initiator and its users:
//   - apb_state_e : initiator FSM states
//   - rsp_cause_e : encoding of why a response was produced
//   - timer register byte addresses (APB slave on the other side)
//   - helpers that map a response cause onto the rsp_err / rsp_timeout flags
// ---------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef enum logic [1:0] {
      CAUSE_OK       = 2'd0,
      CAUSE_SLVERR   = 2'd1,
      CAUSE_MISALIGN = 2'd2,
      CAUSE_TIMEOUT  = 2'd3
   } rsp_cause_e;

   // Timer register map (byte addresses)
   localparam logic [11:0] TCR_ADDR   = 12'h000;
   localparam logic [11:0] TDR0_ADDR  = 12'h004;
   localparam logic [11:0] TDR1_ADDR  = 12'h008;
   localparam logic [11:0] TCMP0_ADDR = 12'h00C;
   localparam logic [11:0] TCMP1_ADDR = 12'h010;
   localparam logic [11:0] TIER_ADDR  = 12'h014;
   localparam logic [11:0] TISR_ADDR  = 12'h018;
   localparam logic [11:0] THCSR_ADDR = 12'h01C;

   // Every cause other than a clean completion is reported as an error
   function automatic logic cause_is_err(input rsp_cause_e cause);
      return (cause != CAUSE_OK);
   endfunction

   // Only the bounded-wait abort raises the timeout flag
   function automatic logic cause_is_timeout(input rsp_cause_e cause);
      return (cause == CAUSE_TIMEOUT);
   endfunction

endpackage

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB4 initiator: turns one valid/ready command into one APB transfer
// (SETUP then ACCESS) and returns exactly one registered response.
// Misaligned commands are answered with an error without touching the bus;
// a slave that keeps pready low longer than TIMEOUT cycles is abandoned.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_write/addr/wdata/strb  command payload
//   rsp_valid/ready     response handshake
//   rsp_rdata           read data (0 for writes and any error)
//   rsp_err/timeout     error flag and timeout-cause flag
//   psel..pstrb         APB request outputs (all registered)
//   prdata/pready/pslverr  APB completion inputs (used only in ACCESS)
// ---------------------------------------------------------------------------
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_W-1:0]     paddr,
   output logic [DATA_W-1:0]     pwdata,
   output logic [DATA_W/8-1:0]   pstrb,
   input  logic [DATA_W-1:0]     prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   apb_state_e state_r;
   logic [7:0] wait_cnt_r;

   // Commands are taken only while idle, so at most one transfer is in flight
   assign cmd_ready = (state_r == IDLE);

   // Transfer FSM with registered APB and response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         wait_cnt_r  <= 8'd0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= {ADDR_W{1'b0}};
         pwdata      <= {DATA_W{1'b0}};
         pstrb       <= {(DATA_W/8){1'b0}};
         rsp_valid   <= 1'b0;
         rsp_rdata   <= {DATA_W{1'b0}};
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_addr[1:0] != 2'b00) begin
                     // Misaligned: answer directly, the bus stays quiet
                     state_r     <= RESP;
                     rsp_valid   <= 1'b1;
                     rsp_rdata   <= {DATA_W{1'b0}};
                     rsp_err     <= cause_is_err(CAUSE_MISALIGN);
                     rsp_timeout <= cause_is_timeout(CAUSE_MISALIGN);
                  end else begin
                     state_r    <= SETUP;
                     wait_cnt_r <= 8'd0;
                     psel       <= 1'b1;
                     penable    <= 1'b0;
                     paddr      <= cmd_addr;
                     pwrite     <= cmd_write;
                     // Reads present zero data and no strobes
                     pwdata     <= cmd_write ? cmd_wdata : {DATA_W{1'b0}};
                     pstrb      <= cmd_write ? cmd_strb  : {(DATA_W/8){1'b0}};
                  end
               end else begin
                  state_r <= IDLE;
               end
            end

            SETUP: begin
               state_r <= ACCESS;
               penable <= 1'b1;
            end

            ACCESS: begin
               if (pready) begin
                  state_r     <= RESP;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  // Read data is returned only for a clean read
                  rsp_rdata   <= (!pwrite && !pslverr) ? prdata : {DATA_W{1'b0}};
                  rsp_err     <= cause_is_err(pslverr ? CAUSE_SLVERR : CAUSE_OK);
                  rsp_timeout <= cause_is_timeout(pslverr ? CAUSE_SLVERR : CAUSE_OK);
               end else if (wait_cnt_r == TIMEOUT_C) begin
                  // TIMEOUT wait cycles already spent; this one is the last
                  state_r     <= RESP;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= {DATA_W{1'b0}};
                  rsp_err     <= cause_is_err(CAUSE_TIMEOUT);
                  rsp_timeout <= cause_is_timeout(CAUSE_TIMEOUT);
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  state_r    <= IDLE;
                  rsp_valid  <= 1'b0;
                  wait_cnt_r <= 8'd0;
               end else begin
                  state_r <= RESP;
               end
            end

            default: begin
               // Unreachable encoding: fall back to a quiet idle bus
               state_r    <= IDLE;
               wait_cnt_r <= 8'd0;
               psel       <= 1'b0;
               penable    <= 1'b0;
               rsp_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;
   import apb_pkg::*;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int TO     = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_strb;
   logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [DATA_W-1:0] rsp_rdata;
   logic              psel, penable, pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [STRB_W-1:0] pstrb;
   logic [DATA_W-1:0] prdata;
   logic              pready, pslverr;

   always #5 clk = ~clk;

   apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
      .pready(pready), .pslverr(pslverr)
   );

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
      logic              tmo;
   } rsp_t;

   rsp_t sb_q[$];
   rsp_t exp_r;
   int   checks = 0;
   int   errors = 0;
   int   lat, psel_cyc, pen_cyc, bus_bad;

   // Drives one command, plays the APB slave, pushes the expected response
   // and returns once rsp_valid is seen (or a cycle budget expires).
   // waits < 0 means pready is held low forever.
   task automatic drive_cmd(input logic w, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] st,
                            input int waits, input logic [DATA_W-1:0] prd,
                            input logic slv);
      rsp_t e;
      logic mis, tmo;
      int   acc, cyc;
      mis     = (addr[1:0] != 2'b00);
      tmo     = !mis && (waits < 0 || waits > TO);
      e.err   = mis | tmo | slv;
      e.tmo   = tmo;
      e.rdata = (!mis && !tmo && !slv && !w) ? prd : 32'h0;
      sb_q.push_back(e);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
      @(posedge clk); #1;
      // Command accepted at this edge; scramble the payload to prove it was latched
      cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_strb = 4'hA; cmd_addr = 12'hFFF;
      psel_cyc = 0; pen_cyc = 0; bus_bad = 0; acc = 0; cyc = 1;
      while (!rsp_valid && cyc < 300) begin
         if (psel) begin
            psel_cyc++;
            if (paddr !== addr || pwrite !== w || pwdata !== (w ? wd : 32'h0) ||
                pstrb !== (w ? st : 4'h0)) bus_bad++;
            if (psel_cyc == 1 && penable !== 1'b0) bus_bad++;
         end
         if (psel && penable) begin
            pen_cyc++;
            if (waits >= 0 && acc == waits) begin
               pready = 1'b1; prdata = prd; pslverr = slv;
            end else begin
               pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
            end
            acc++;
         end else begin
            // Noise that must be ignored outside ACCESS
            pready = 1'b1; prdata = 32'hBAD0_BAD0; pslverr = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      lat = cyc;
      if (!rsp_valid) begin
         checks++; errors++;
         $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, cyc);
      end
   endtask

   // Completes the response handshake
   task automatic consume_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({psel, penable, pwrite} !== 3'b000) begin
         errors++; $display("FAIL reset_ctl: psel/penable/pwrite=%b required 000", {psel, penable, pwrite});
      end
      checks++;
      if ({paddr, pwdata, pstrb} !== 48'h0) begin
         errors++; $display("FAIL reset_bus: paddr=%h pwdata=%h pstrb=%h required 0", paddr, pwdata, pstrb);
      end
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== 35'h0) begin
         errors++; $display("FAIL reset_rsp: valid=%b rdata=%h err=%b tmo=%b required 0", rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
      end
   endtask

   task automatic test_write_tcr();
      drive_cmd(1'b1, TCR_ADDR, 32'h0000_0103, 4'hF, 0, 32'h0, 1'b0);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d required 3", lat); end
      checks++;
      if (psel_cyc !== 2 || pen_cyc !== 1) begin
         errors++; $display("FAIL wr_phases: psel=%0d penable=%0d cycles required 2/1", psel_cyc, pen_cyc);
      end
      checks++;
      if (bus_bad !== 0) begin errors++; $display("FAIL wr_bus: %0d bad bus cycles required 0", bus_bad); end
      exp_r = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== exp_r) begin
         errors++; $display("FAIL wr_rsp: rdata=%h err=%b tmo=%b required %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, exp_r.rdata, exp_r.err, exp_r.tmo);
      end
      consume_rsp();
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL wr_release: cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
      end
   endtask

   task automatic test_read_wait();
      drive_cmd(1'b0, TIER_ADDR, 32'h5555_5555, 4'hF, 3, 32'h0000_0001, 1'b0);
      checks++;
      if (pen_cyc !== 4 || lat !== 6) begin
         errors++; $display("FAIL rd_wait_len: access=%0d latency=%0d required 4/6", pen_cyc, lat);
      end
      checks++;
      if (bus_bad !== 0) begin errors++; $display("FAIL rd_bus: %0d bad bus cycles required 0", bus_bad); end
      exp_r = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== exp_r) begin
         errors++; $display("FAIL rd_rsp: rdata=%h err=%b tmo=%b required %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, exp_r.rdata, exp_r.err, exp_r.tmo);
      end
      consume_rsp();
   endtask

   task automatic test_timeout();
      drive_cmd(1'b0, TDR1_ADDR, 32'h0, 4'h0, -1, 32'h0, 1'b0);
      checks++;
      if (pen_cyc !== TO + 1 || lat !== TO + 3) begin
         errors++; $display("FAIL to_len: access=%0d latency=%0d required %0d/%0d", pen_cyc, lat, TO + 1, TO + 3);
      end
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0) begin
         errors++; $display("FAIL to_bus_idle: psel=%b penable=%b required 0/0", psel, penable);
      end
      exp_r = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== exp_r) begin
         errors++; $display("FAIL to_rsp: rdata=%h err=%b tmo=%b required %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, exp_r.rdata, exp_r.err, exp_r.tmo);
      end
      consume_rsp();
   endtask

   task automatic test_slverr();
      drive_cmd(1'b1, TCMP0_ADDR, 32'h1234_0000, 4'h3, 1, 32'h0, 1'b1);
      exp_r = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== exp_r) begin
         errors++; $display("FAIL slverr_rsp: rdata=%h err=%b tmo=%b required %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, exp_r.rdata, exp_r.err, exp_r.tmo);
      end
      consume_rsp();
      drive_cmd(1'b0, TCMP0_ADDR, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b0);
      exp_r = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== exp_r || bus_bad !== 0) begin
         errors++; $display("FAIL slverr_followup: rdata=%h err=%b tmo=%b bad=%0d required %h/%b/%b/0", rsp_rdata, rsp_err, rsp_timeout, bus_bad, exp_r.rdata, exp_r.err, exp_r.tmo);
      end
      consume_rsp();
   endtask

   task automatic test_misaligned();
      drive_cmd(1'b1, 12'h006, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0);
      checks++;
      if (lat !== 1 || psel_cyc !== 0) begin
         errors++; $display("FAIL mis_timing: latency=%0d psel_cycles=%0d required 1/0", lat, psel_cyc);
      end
      exp_r = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== exp_r) begin
         errors++; $display("FAIL mis_rsp: rdata=%h err=%b tmo=%b required %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, exp_r.rdata, exp_r.err, exp_r.tmo);
      end
      consume_rsp();
   endtask

   task automatic test_backpressure();
      drive_cmd(1'b0, TDR0_ADDR, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);
      exp_r = sb_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rsp_valid, cmd_ready, psel, rsp_rdata, rsp_err, rsp_timeout} !== {3'b100, exp_r}) begin
            errors++; $display("FAIL bp_hold[%0d]: valid=%b cmd_ready=%b psel=%b rdata=%h err=%b tmo=%b required 1/0/0/%h/%b/%b",
                               i, rsp_valid, cmd_ready, psel, rsp_rdata, rsp_err, rsp_timeout, exp_r.rdata, exp_r.err, exp_r.tmo);
         end
         @(posedge clk); #1;
      end
      consume_rsp();
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release: cmd_ready=%b required 1", cmd_ready); end
   endtask

   task automatic test_back_to_back();
      drive_cmd(1'b1, TCMP1_ADDR, 32'h0000_00FF, 4'h1, 0, 32'h0, 1'b0);
      exp_r = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== exp_r || bus_bad !== 0 || lat !== 3) begin
         errors++; $display("FAIL b2b_first: rdata=%h err=%b bad=%0d lat=%0d required %h/%b/0/3", rsp_rdata, rsp_err, bus_bad, lat, exp_r.rdata, exp_r.err);
      end
      consume_rsp();
      drive_cmd(1'b0, TISR_ADDR, 32'h0, 4'h0, 2, 32'hA5A5_0003, 1'b0);
      exp_r = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== exp_r || bus_bad !== 0 || lat !== 5) begin
         errors++; $display("FAIL b2b_second: rdata=%h err=%b bad=%0d lat=%0d required %h/%b/0/5", rsp_rdata, rsp_err, bus_bad, lat, exp_r.rdata, exp_r.err);
      end
      consume_rsp();
   endtask

   task automatic test_reset_mid();
      int n;
      int stray;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = TDR0_ADDR; cmd_strb = 4'h0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      pready = 1'b0;
      n = 0;
      while (!penable && n < 10) begin @(posedge clk); #1; n++; end
      checks++;
      if (penable !== 1'b1) begin errors++; $display("FAIL rstmid_reach_access: penable=%b required 1", penable); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b000 || paddr !== 12'h0) begin
         errors++; $display("FAIL rstmid_async: psel=%b penable=%b rsp_valid=%b paddr=%h required 0", psel, penable, rsp_valid, paddr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready: got %b required 1", cmd_ready); end
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid !== 1'b0 || psel !== 1'b0) stray++;
         @(posedge clk); #1;
      end
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL rstmid_no_rsp: %0d cycles with activity required 0", stray); end
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0;
      cmd_wdata = 32'h0; cmd_strb = 4'h0; rsp_ready = 1'b0;
      prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_write_tcr();
      test_read_wait();
      test_timeout();
      test_slverr();
      test_misaligned();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sb_q.size() !== 0) begin
         errors++; $display("FAIL sb_leftover: %0d responses never produced, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_master.md
# apb_master

APB4 initiator that converts a simple valid/ready command stream into APB setup and access phases. It sits between a host-side command source (CPU bridge or test sequencer) and the timer's APB slave port. Each accepted command produces one APB transfer. The block handles slave wait states, slave errors, misaligned addresses and a bounded-wait timeout, and returns one response per command.

## Interface
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width (strobe width DATA_W/8)
- TIMEOUT, 255, maximum ACCESS cycles with pready low before abort (1..255)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  pslverr, misalignment or timeout
- rsp_timeout  out  1  timeout cause flag
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pstrb  out  DATA_W/8  APB strobes
- prdata  in  DATA_W  APB read data
- pready, pslverr  in  1  APB completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready = 1. cmd_ready is combinational, equal to (state == IDLE).
  - On cmd_valid & cmd_ready, latch the command.
  - If cmd_addr[1:0] != 0, go to RESP with rsp_err = 1. No bus activity occurs.
  - Otherwise go to SETUP.
- SETUP: psel = 1, penable = 0; paddr, pwrite, pwdata and pstrb are driven from the latched command. Next state is ACCESS unconditionally.
- ACCESS: psel = 1, penable = 1, with all APB outputs held stable.
  - On pready: capture prdata (reads only) and pslverr into rsp_err, then go to RESP.
  - Each ACCESS cycle with pready = 0 increments an 8-bit wait counter.
  - When the counter equals TIMEOUT and pready is still 0: set rsp_err = 1 and rsp_timeout = 1, force rsp_rdata = 0, and go to RESP.
- RESP: psel = penable = 0, rsp_valid = 1, response fields held stable. On rsp_ready, go to IDLE and clear the wait counter.
- Reads drive pwdata = 0 and pstrb = 0. Writes drive pstrb = cmd_strb.
- Response fields are registered. rsp_rdata is 0 on write, pslverr, misalignment and timeout.
- No command pipelining: at most one transaction is outstanding.

## Timing
- Reset values: state = IDLE, psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0, pstrb = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_timeout = 0, wait counter = 0. cmd_ready = 1 after reset.
- Command accepted at edge N: SETUP during N+1, ACCESS from N+2.
  - With pready = 1 in the first ACCESS cycle: rsp_valid = 1 in N+3. This is the minimum latency of 3 cycles.
  - Each cycle of pready = 0 adds one cycle.
- Timeout: with pready stuck low, ACCESS lasts TIMEOUT+1 cycles, then RESP follows.
- Misaligned command: rsp_valid = 1 at N+1 and psel never asserts.
- rsp_valid & rsp_ready at edge M: cmd_ready = 1 in M+1. No same-cycle command acceptance during RESP.
- pready and pslverr are ignored outside ACCESS. prdata is sampled only on the pready edge.
- Reset asserted mid-transfer: all outputs return to reset values immediately, and the aborted transfer produces no response.

## Structure
- Shared package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - response-cause encoding;
  - timer register address constants: TCR 0x000, TDR0 0x004, TDR1 0x008, TCMP0 0x00C, TCMP1 0x010, TIER 0x014, TISR 0x018, THCSR 0x01C.
- Single module. The wait counter and FSM are inline; no sub-module is needed.

## Test plan
- Write 0x0000_0103 to TCR (0x000), strb 0xF, pready tied 1 -> psel high 2 cycles (penable only in the 2nd), pwrite = 1, pwdata = 0x0000_0103; rsp_valid at N+3 with err = 0, rdata = 0.
- Read TIER (0x014), pready low for 3 ACCESS cycles then high with prdata = 0x1 -> ACCESS lasts 4 cycles, pstrb = 0, pwdata = 0; rsp_rdata = 0x1, rsp_err = 0.
- TIMEOUT = 4, read 0x008, pready held 0 -> ACCESS lasts exactly 5 cycles, then psel = 0; rsp_err = 1, rsp_timeout = 1, rdata = 0.
- Write 0x00C with pslverr = 1 on the pready cycle -> rsp_err = 1, rsp_timeout = 0. A following read of 0x00C returning 0xFFFF_FFFF completes cleanly.
- Command to address 0x006 -> psel stays 0; rsp_valid = 1 at N+1 with rsp_err = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles -> response stable and cmd_ready = 0 throughout. rst_n pulsed during ACCESS -> psel, penable and rsp_valid go 0 at once, and cmd_ready = 1 after release.
